// File: rtl/ulpi_reg_access_if.sv
// ulpi_reg_access_if
// Bundles the register-request handshake from the control logic and the
// link side of the ULPI bus used by ulpi_reg_access.
// slave  : the register engine (consumes requests, drives stp/data).
// master : the requester / PHY side that drives requests and dir/nxt/data.
interface ulpi_reg_access_if;
    // Register request side
    logic       i_enable;
    logic       i_req;
    logic       i_we;
    logic [7:0] i_addr;
    logic [7:0] i_wdata;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [7:0] o_rdata;
    // ULPI bus side
    logic       i_dir;
    logic       i_nxt;
    logic [7:0] i_data;
    logic       o_stp;
    logic [7:0] o_data;
    logic       o_data_oe;

    modport slave (
        input  i_enable, i_req, i_we, i_addr, i_wdata,
        input  i_dir, i_nxt, i_data,
        output o_busy, o_done, o_err, o_rdata,
        output o_stp, o_data, o_data_oe
    );

    modport master (
        output i_enable, i_req, i_we, i_addr, i_wdata,
        output i_dir, i_nxt, i_data,
        input  o_busy, o_done, o_err, o_rdata,
        input  o_stp, o_data, o_data_oe
    );
endinterface

// File: rtl/ulpi_reg_access.sv
// ulpi_reg_access
// Link-side ULPI PHY register read/write engine. Turns one register request
// into a TX CMD sequence, follows the nxt/dir handshake, retries after PHY
// aborts and gives up with an error after a timeout or too many retries.
// Optional build macro: ULPI_REG_EXT_ADDR_EN enables extended register
// addressing (addresses above 0x3E are sent through an extra TX_EXT byte).
module ulpi_reg_access #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRY      = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    ulpi_reg_access_if.slave bus
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);
`ifdef ULPI_REG_EXT_ADDR_EN
    localparam int ADDR_W = 8;
`else
    localparam int ADDR_W = 6;
`endif

    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        IDLE,
        TX_CMD,
`ifdef ULPI_REG_EXT_ADDR_EN
        TX_EXT,
`endif
        TX_DATA,
        TX_STP,
        RD_TURN,
        RD_DATA,
        RD_BACK,
        RD_TA,
        WAIT_DIR_LOW,
        ABORT_TA,
        DONE
    } state_t;

    state_t            state_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        wdata_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;
    logic              err_flag_reg;
    logic [7:0]        rdata_reg;
    logic              stp_reg;
    logic [7:0]        data_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic [RTY_W-1:0]  retry_cnt_reg;
    logic              drive;
    logic              tmo_hit;

`ifndef ULPI_REG_EXT_ADDR_EN
    // Upper address bits have no meaning without extended addressing.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, bus.i_addr[7:6]};
`endif

    // TX CMD byte: register write 2'b10 / read 2'b11 plus the address field.
    function automatic logic [7:0] cmd_byte(input logic we, input logic [ADDR_W-1:0] addr);
        logic [1:0] op;
        op = we ? 2'b10 : 2'b11;
`ifdef ULPI_REG_EXT_ADDR_EN
        if (addr > 8'h3E) begin
            return {op, 6'b101111};
        end
`endif
        return {op, addr[5:0]};
    endfunction

    // Link owns the bus only in the transmit states, and never while dir is high.
    assign drive = (state_reg == TX_CMD)
`ifdef ULPI_REG_EXT_ADDR_EN
                || (state_reg == TX_EXT)
`endif
                || (state_reg == TX_DATA)
                || (state_reg == TX_STP);

    assign tmo_hit = (tmo_cnt_reg == TMO_LAST);

    assign bus.o_data_oe = drive && !bus.i_dir;
    assign bus.o_busy    = busy_reg;
    assign bus.o_done    = done_reg;
    assign bus.o_err     = err_reg;
    assign bus.o_rdata   = rdata_reg;
    assign bus.o_stp     = stp_reg;
    assign bus.o_data    = data_reg;

    // Main sequencer: state, registered outputs, retry and timeout counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            err_flag_reg  <= 1'b0;
            rdata_reg     <= '0;
            stp_reg       <= 1'b0;
            data_reg      <= '0;
            tmo_cnt_reg   <= '0;
            retry_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // dir high means the PHY owns the bus: hold the request off.
                    if (bus.i_req && bus.i_enable && !bus.i_dir) begin
                        we_reg        <= bus.i_we;
                        addr_reg      <= bus.i_addr[ADDR_W-1:0];
                        wdata_reg     <= bus.i_wdata;
                        busy_reg      <= 1'b1;
                        err_reg       <= 1'b0;
                        err_flag_reg  <= 1'b0;
                        retry_cnt_reg <= '0;
                        tmo_cnt_reg   <= '0;
                        data_reg      <= cmd_byte(bus.i_we, bus.i_addr[ADDR_W-1:0]);
                        state_reg     <= TX_CMD;
                    end
                end

                TX_CMD: begin
                    if (bus.i_dir) begin
                        data_reg    <= '0;
                        tmo_cnt_reg <= '0;
                        state_reg   <= WAIT_DIR_LOW;
`ifdef ULPI_REG_EXT_ADDR_EN
                    end else if (bus.i_nxt && (addr_reg > 8'h3E)) begin
                        data_reg    <= addr_reg;
                        tmo_cnt_reg <= '0;
                        state_reg   <= TX_EXT;
`endif
                    end else if (bus.i_nxt && we_reg) begin
                        data_reg    <= wdata_reg;
                        tmo_cnt_reg <= '0;
                        state_reg   <= TX_DATA;
                    end else if (bus.i_nxt) begin
                        data_reg    <= '0;
                        tmo_cnt_reg <= '0;
                        state_reg   <= RD_TURN;
                    end else if (tmo_hit) begin
                        // We were driving, so terminate with stp before reporting.
                        data_reg     <= '0;
                        stp_reg      <= 1'b1;
                        err_flag_reg <= 1'b1;
                        tmo_cnt_reg  <= '0;
                        state_reg    <= TX_STP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end

`ifdef ULPI_REG_EXT_ADDR_EN
                TX_EXT: begin
                    if (bus.i_dir) begin
                        data_reg    <= '0;
                        tmo_cnt_reg <= '0;
                        state_reg   <= WAIT_DIR_LOW;
                    end else if (bus.i_nxt && we_reg) begin
                        data_reg    <= wdata_reg;
                        tmo_cnt_reg <= '0;
                        state_reg   <= TX_DATA;
                    end else if (bus.i_nxt) begin
                        data_reg    <= '0;
                        tmo_cnt_reg <= '0;
                        state_reg   <= RD_TURN;
                    end else if (tmo_hit) begin
                        data_reg     <= '0;
                        stp_reg      <= 1'b1;
                        err_flag_reg <= 1'b1;
                        tmo_cnt_reg  <= '0;
                        state_reg    <= TX_STP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
`endif

                TX_DATA: begin
                    if (bus.i_dir) begin
                        data_reg    <= '0;
                        tmo_cnt_reg <= '0;
                        state_reg   <= WAIT_DIR_LOW;
                    end else if (bus.i_nxt) begin
                        data_reg    <= '0;
                        stp_reg     <= 1'b1;
                        tmo_cnt_reg <= '0;
                        state_reg   <= TX_STP;
                    end else if (tmo_hit) begin
                        data_reg     <= '0;
                        stp_reg      <= 1'b1;
                        err_flag_reg <= 1'b1;
                        tmo_cnt_reg  <= '0;
                        state_reg    <= TX_STP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end

                TX_STP: begin
                    // stp is a single-cycle pulse; completion follows directly.
                    stp_reg   <= 1'b0;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    err_reg   <= err_flag_reg;
                    state_reg <= DONE;
                end

                RD_TURN: begin
                    if (bus.i_dir && bus.i_nxt) begin
                        // RX CMD instead of read data: PHY aborted the read.
                        tmo_cnt_reg <= '0;
                        state_reg   <= WAIT_DIR_LOW;
                    end else if (bus.i_dir) begin
                        tmo_cnt_reg <= '0;
                        state_reg   <= RD_DATA;
                    end else if (tmo_hit) begin
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        err_reg     <= 1'b1;
                        tmo_cnt_reg <= '0;
                        state_reg   <= DONE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end

                RD_DATA: begin
                    if (bus.i_dir && !bus.i_nxt) begin
                        rdata_reg   <= bus.i_data;
                        tmo_cnt_reg <= '0;
                        state_reg   <= RD_BACK;
                    end else if (tmo_hit) begin
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        err_reg     <= 1'b1;
                        tmo_cnt_reg <= '0;
                        state_reg   <= DONE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end

                RD_BACK: begin
                    if (!bus.i_dir) begin
                        state_reg <= RD_TA;
                    end
                end

                RD_TA: begin
                    // Turnaround cycle after the PHY hands the bus back.
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    state_reg <= DONE;
                end

                WAIT_DIR_LOW: begin
                    // No timeout here: the PHY may hold the bus for as long as it needs.
                    if (!bus.i_dir) begin
                        state_reg <= ABORT_TA;
                    end
                end

                ABORT_TA: begin
                    retry_cnt_reg <= retry_cnt_reg + 1'b1;
                    tmo_cnt_reg   <= '0;
                    if (retry_cnt_reg == RTY_LIMIT) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        err_reg   <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        data_reg  <= cmd_byte(we_reg, addr_reg);
                        state_reg <= TX_CMD;
                    end
                end

                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ulpi_reg_access.sv
// tb_ulpi_reg_access
// Directed bench for ulpi_reg_access: a table of clean read/write
// transactions plus hand-written abort, timeout, reset and hold-off cases.
module tb_ulpi_reg_access;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ulpi_reg_access_if bus();

    ulpi_reg_access #(
        .TIMEOUT_CYCLES(255),
        .MAX_RETRY(3)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] phy_data;
        logic [7:0] exp_cmd;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clean transaction: nxt immediate on CMD/DATA, PHY returns data on reads.
    task automatic run_vec(input int idx, input vec_t v);
        bus.i_req   = 1'b1;
        bus.i_we    = v.we;
        bus.i_addr  = v.addr;
        bus.i_wdata = v.wdata;
        bus.i_dir   = 1'b0;
        bus.i_nxt   = 1'b0;
        step();
        bus.i_req = 1'b0;
        chk1("busy_accept", bus.o_busy, 1'b1);
        chk1("err_clear", bus.o_err, 1'b0);
        chk8("tx_cmd", bus.o_data, v.exp_cmd);
        chk1("oe_cmd", bus.o_data_oe, 1'b1);
        bus.i_nxt = 1'b1;
        step();
        if (v.we) begin
            chk8("tx_data", bus.o_data, v.wdata);
            chk1("oe_data", bus.o_data_oe, 1'b1);
            step();
            bus.i_nxt = 1'b0;
            chk1("stp", bus.o_stp, 1'b1);
            chk8("stp_data", bus.o_data, 8'h00);
            step();
        end else begin
            bus.i_nxt = 1'b0;
            bus.i_dir = 1'b1;
            #1;
            chk1("oe_turn", bus.o_data_oe, 1'b0);
            step();
            bus.i_data = v.phy_data;
            step();
            bus.i_dir  = 1'b0;
            bus.i_data = 8'h00;
            step();
            chk1("ta_no_done", bus.o_done, 1'b0);
            chk1("oe_ta", bus.o_data_oe, 1'b0);
            step();
        end
        chk1("done", bus.o_done, 1'b1);
        chk1("busy_done", bus.o_busy, 1'b0);
        chk1("err_done", bus.o_err, 1'b0);
        chk1("stp_done", bus.o_stp, 1'b0);
        chk8("rdata", bus.o_rdata, v.exp_rdata);
        step();
        chk1("done_pulse", bus.o_done, 1'b0);
        $display("vec %0d we=%0b addr=0x%02h wdata=0x%02h rdata=0x%02h", idx, v.we, v.addr, v.wdata, bus.o_rdata);
    endtask

    initial begin
        int n;

        vecs[0] = '{1'b1, 8'h04, 8'h45, 8'h00, 8'h84, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 8'h24, 8'hC0, 8'h24};
        vecs[2] = '{1'b1, 8'h3E, 8'hA5, 8'h00, 8'hBE, 8'h24};
        vecs[3] = '{1'b0, 8'h15, 8'h00, 8'hFF, 8'hD5, 8'hFF};
        vecs[4] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h80, 8'hFF};
        vecs[5] = '{1'b0, 8'h3E, 8'h00, 8'h5A, 8'hFE, 8'h5A};

        rst          = 1'b0;
        bus.i_enable = 1'b1;
        bus.i_req    = 1'b0;
        bus.i_we     = 1'b0;
        bus.i_addr   = 8'h00;
        bus.i_wdata  = 8'h00;
        bus.i_dir    = 1'b0;
        bus.i_nxt    = 1'b0;
        bus.i_data   = 8'h00;
        #3 rst = 1'b1;
        #10;
        chk1("rst_busy", bus.o_busy, 1'b0);
        chk1("rst_done", bus.o_done, 1'b0);
        chk1("rst_err", bus.o_err, 1'b0);
        chk8("rst_rdata", bus.o_rdata, 8'h00);
        chk1("rst_stp", bus.o_stp, 1'b0);
        chk8("rst_data", bus.o_data, 8'h00);
        chk1("rst_oe", bus.o_data_oe, 1'b0);
        rst = 1'b0;
        $display("reset released");
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Write with dir rising during TX_CMD once, then a clean retry.
        bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_addr = 8'h04; bus.i_wdata = 8'h45;
        step();
        bus.i_req = 1'b0;
        chk8("ab_cmd", bus.o_data, 8'h84);
        bus.i_dir = 1'b1;
        #1;
        chk1("ab_oe_release", bus.o_data_oe, 1'b0);
        step();
        step();
        chk1("ab_busy_wait", bus.o_busy, 1'b1);
        chk1("ab_oe_wait", bus.o_data_oe, 1'b0);
        bus.i_dir = 1'b0;
        step();
        chk1("ab_oe_ta", bus.o_data_oe, 1'b0);
        step();
        chk8("ab_recmd", bus.o_data, 8'h84);
        chk1("ab_oe_recmd", bus.o_data_oe, 1'b1);
        bus.i_nxt = 1'b1;
        step();
        chk8("ab_data", bus.o_data, 8'h45);
        step();
        bus.i_nxt = 1'b0;
        chk1("ab_stp", bus.o_stp, 1'b1);
        step();
        chk1("ab_done", bus.o_done, 1'b1);
        chk1("ab_err", bus.o_err, 1'b0);
        step();
        $display("txn dir-abort write retry done");

        // Read aborted by RX CMD on every attempt: error after 3 retries.
        bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 8'h00;
        step();
        bus.i_req = 1'b0;
        chk8("rx_cmd0", bus.o_data, 8'hC0);
        for (int a = 0; a < 4; a++) begin
            bus.i_nxt = 1'b1;
            step();
            bus.i_dir = 1'b1;
            bus.i_nxt = 1'b1;
            #1;
            chk1("rx_oe", bus.o_data_oe, 1'b0);
            step();
            bus.i_dir = 1'b0;
            bus.i_nxt = 1'b0;
            step();
            chk1("rx_busy_ta", bus.o_busy, 1'b1);
            chk1("rx_nodone_ta", bus.o_done, 1'b0);
            step();
            if (a < 3) begin
                chk8("rx_recmd", bus.o_data, 8'hC0);
                chk1("rx_nodone", bus.o_done, 1'b0);
            end else begin
                chk1("rx_done", bus.o_done, 1'b1);
                chk1("rx_err", bus.o_err, 1'b1);
                chk1("rx_busy", bus.o_busy, 1'b0);
            end
        end
        step();
        chk8("rx_rdata_held", bus.o_rdata, 8'h5A);
        $display("txn read abort x4 err=%0b", bus.o_err);

        // nxt never asserted on a write: timeout after 255 cycles.
        bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_addr = 8'h04; bus.i_wdata = 8'h11;
        step();
        bus.i_req = 1'b0;
        n = 0;
        while (!bus.o_stp && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (n != 255) begin
            failures++;
            $display("FAIL tmo_cycles: got %0d expected 255", n);
        end
        chk8("tmo_stp_data", bus.o_data, 8'h00);
        step();
        chk1("tmo_done", bus.o_done, 1'b1);
        chk1("tmo_err", bus.o_err, 1'b1);
        chk1("tmo_stp_off", bus.o_stp, 1'b0);
        step();
        chk1("tmo_err_held", bus.o_err, 1'b1);
        $display("txn write timeout after %0d cycles", n);

        // Async reset in TX_DATA.
        bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_addr = 8'h10; bus.i_wdata = 8'h33;
        step();
        bus.i_req = 1'b0;
        bus.i_nxt = 1'b1;
        step();
        chk8("rs_data", bus.o_data, 8'h33);
        #2 rst = 1'b1;
        #1;
        chk1("rs_busy", bus.o_busy, 1'b0);
        chk1("rs_oe", bus.o_data_oe, 1'b0);
        chk1("rs_stp", bus.o_stp, 1'b0);
        chk1("rs_err", bus.o_err, 1'b0);
        bus.i_nxt = 1'b0;
        #2 rst = 1'b0;
        $display("txn reset in TX_DATA");
        run_vec(6, vecs[0]);

        // Request while dir is high, and request while disabled: both ignored.
        bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_addr = 8'h04; bus.i_dir = 1'b1;
        step();
        chk1("dir_holdoff", bus.o_busy, 1'b0);
        bus.i_req = 1'b0; bus.i_dir = 1'b0;
        step();
        bus.i_enable = 1'b0; bus.i_req = 1'b1;
        step();
        chk1("enable_holdoff", bus.o_busy, 1'b0);
        step();
        chk1("enable_holdoff2", bus.o_busy, 1'b0);
        bus.i_req = 1'b0; bus.i_enable = 1'b1;
        step();
        $display("txn hold-off checks");

        // Address above 0x3E.
        bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_wdata = 8'h5C;
`ifdef ULPI_REG_EXT_ADDR_EN
        bus.i_addr = 8'h80;
        step();
        bus.i_req = 1'b0;
        chk8("ext_cmd", bus.o_data, 8'hAF);
        bus.i_nxt = 1'b1;
        step();
        chk8("ext_addr", bus.o_data, 8'h80);
        step();
        chk8("ext_wdata", bus.o_data, 8'h5C);
`else
        bus.i_addr = 8'hC4;
        step();
        bus.i_req = 1'b0;
        chk8("hi_cmd", bus.o_data, 8'h84);
        bus.i_nxt = 1'b1;
        step();
        chk8("hi_wdata", bus.o_data, 8'h5C);
`endif
        step();
        bus.i_nxt = 1'b0;
        chk1("hi_stp", bus.o_stp, 1'b1);
        step();
        chk1("hi_done", bus.o_done, 1'b1);
        chk1("hi_err", bus.o_err, 1'b0);
        step();
        $display("txn high address write");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ulpi_reg_access.md
Name: ulpi_reg_access

Overview:
- Link-side ULPI PHY register read/write engine. Sits beside ulpi_ctrl on the same ULPI bus and is enabled once ulpi_ctrl finishes its reset sequence.
- Converts single-word register requests from the control logic into ULPI TX CMD sequences on the bus.
- Handles nxt/dir handshakes, bus turnaround and PHY aborts.
- Returns read data together with done and error status.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait for nxt, or for read data, before aborting with error.
- MAX_RETRY, 3: PHY-abort retries before reporting error.

Ports:
- i_clk  input  1  ULPI 60 MHz clock.
- i_rst  input  1  async active-high reset.
- i_enable  input  1  high when ulpi_ctrl reset sequence is finished; requests are ignored while low.
- i_req  input  1  request strobe; sampled only in IDLE.
- i_we  input  1  1 = write, 0 = read.
- i_addr  input  8  register address; bits [5:0] used unless extended addressing is enabled.
- i_wdata  input  8  write data.
- o_busy  output  1  high from accept until done.
- o_done  output  1  one-cycle completion pulse.
- o_err  output  1  valid with o_done: timeout or retries exhausted.
- o_rdata  output  8  read result; held until the next read completes.
- i_dir  input  1  ULPI dir.
- i_nxt  input  1  ULPI nxt.
- o_stp  output  1  ULPI stp.
- o_data  output  8  ULPI data out.
- o_data_oe  output  1  data output enable.

Behaviour:
- Reset (async): state IDLE; o_busy=0, o_done=0, o_err=0, o_rdata=0, o_stp=0, o_data=0, retry and timeout counters 0.
- Bus gating: o_data_oe = (state drives the bus) && !i_dir. This is combinational, so the link releases the bus in the same cycle dir rises.
- Request accept: in IDLE, i_req && i_enable && !i_dir.
  - Latch we/addr/wdata, set o_busy, go to TX_CMD.
  - A request arriving while dir=1 is held off; i_req must stay high until o_busy is seen.
- TX_CMD:
  - Drive o_data = {i_we ? 2'b10 : 2'b11, addr[5:0]}.
  - On i_nxt=1: write -> TX_DATA; read -> RD_TURN.
- TX_DATA:
  - Drive wdata.
  - On i_nxt=1 -> TX_STP.
- TX_STP:
  - o_stp=1 for exactly one cycle, o_data=0.
  - Then DONE.
  - Write latency with nxt immediate: accept +1 CMD, +1 DATA, +1 STP, +1 DONE pulse.
- RD_TURN:
  - Bus released.
  - i_dir=1 && i_nxt=0 -> RD_DATA.
  - i_dir=1 && i_nxt=1 -> PHY abort.
- RD_DATA:
  - When i_dir=1 && i_nxt=0, capture i_data into o_rdata, then go to RD_BACK.
- RD_BACK:
  - Wait for i_dir=0.
  - Then one turnaround cycle with the bus released.
  - Then DONE.
- PHY abort:
  - Trigger: i_dir rises in TX_CMD or TX_DATA before nxt, or i_dir=1 && i_nxt=1 in RD_TURN.
  - Go to WAIT_DIR_LOW with the bus released.
  - Once dir=0, wait one turnaround cycle, increment the retry count and restart at TX_CMD.
  - If the retry count exceeds MAX_RETRY -> DONE with o_err=1.
- Timeout:
  - A counter resets on every state change.
  - It reaching TIMEOUT_CYCLES in TX_CMD, TX_DATA, RD_TURN or RD_DATA -> DONE with o_err=1.
  - If the bus was being driven, o_stp pulses for one cycle first.
  - WAIT_DIR_LOW has no timeout.
- DONE:
  - o_done=1 for one cycle; o_busy drops in the same cycle.
  - Return to IDLE.
  - o_err is cleared at the next accept.
- i_enable falling mid-operation: the current operation completes normally. There is no abort.
- A simultaneous i_req and dir rise in IDLE: dir wins and the request is not accepted.

Optional Feature:
- ULPI_REG_EXT_ADDR_EN defined:
  - When i_addr > 8'h3E, TX_CMD sends address 6'b101111.
  - An extra TX_EXT state then drives i_addr after nxt, and must itself receive nxt before continuing.
  - A PHY abort in TX_EXT behaves the same as an abort in TX_CMD.
- Not defined: i_addr[7:6] is ignored, and there is no TX_EXT state.

Test Plan:
- Write addr 0x04, data 0x45, nxt high on CMD and DATA:
  - data shows 0x84 then 0x45, stp pulses 1 cycle, o_done 4 cycles after accept, o_err=0.
- Read addr 0x00, PHY turns around and returns 0x24:
  - data shows 0xC0, o_rdata=0x24, o_done after dir falls plus 1 turnaround, o_data_oe=0 while dir=1.
- Write with dir rising during TX_CMD once, then a clean retry:
  - bus released the same cycle dir rises, TX_CMD 0x84 re-issued after dir low plus 1, o_err=0.
- Read with RX CMD abort (dir=1, nxt=1) on every attempt:
  - after MAX_RETRY=3 retries, o_done with o_err=1.
- nxt never asserted during write:
  - after 255 cycles, stp pulse then o_done with o_err=1.
- Async reset asserted in TX_DATA:
  - immediately o_busy=0, o_data_oe=0, o_stp=0; next request works normally.
- With ULPI_REG_EXT_ADDR_EN, write addr 0x80:
  - data sequence 0xAF, 0x80, wdata, then stp.
